// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : Shared timing constants for the standard 640x480@60 VGA mode and
//           a helper that sums the four segments of a line or frame into its
//           total length. Imported by the timing generator so its parameter
//           defaults and derived totals come from one place.
// Contents: VGA_* segment widths, pipeline/counter defaults, vga_total().
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal segments, in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical segments, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Output latency in enabled cycles and coordinate counter width
    localparam int VGA_PIPE_DEFAULT = 2;
    localparam int VGA_CW_DEFAULT   = 10;

    // Sums the visible region and the three blanking segments into the
    // total number of pixels per line (or lines per frame).
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_pipe_delay.sv
// ----------------------------------------------------------------------------
// vga_pipe_delay
// Purpose : WIDTH-bit wide, DEPTH-stage shift register that advances only on
//           clock-enable cycles. A synchronous reset loads every stage with a
//           caller-supplied idle word, so the output is well defined during
//           the first DEPTH enabled cycles after reset.
// Ports   : i_clk      - clock
//           i_rst      - synchronous active-high reset (wins over i_ce)
//           i_ce       - shift enable
//           i_data     - word entering stage 0
//           i_rst_val  - word loaded into every stage on reset
//           o_data     - word leaving the last stage
// ----------------------------------------------------------------------------
module vga_pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_rst_val,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Reset flushes the whole chain with the idle word so nothing captured
    // before reset can leak out afterwards. Otherwise the chain only moves
    // on enabled cycles, which keeps the latency counted in pixels rather
    // than in clocks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= i_rst_val;
            end
        end else if (i_ce) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : Generates VGA horizontal/vertical sync, the visible-region flag,
//           pixel coordinates and line/frame start strobes from a column and
//           a row counter that advance on a pixel clock enable. All outputs
//           leave through the same PIPE-stage delay so they stay aligned.
// Ports   : CLK          - clock
//           RST          - synchronous active-high reset
//           CE           - pixel clock enable
//           H_Sync       - horizontal sync, asserted level = H_POL
//           V_Sync       - vertical sync, asserted level = V_POL
//           Active       - high inside the visible region
//           Col, Row     - coordinates of the pixel the other outputs describe
//           Line_Start   - high for the first pixel of every line
//           Frame_Start  - high for the first pixel of every frame
// Notes   : PIPE must be 1..4 and CW wide enough for the larger of the line
//           and frame totals. Strobes stay high while CE is low; consumers
//           qualify them with CE.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   PIPE     = VGA_PIPE_DEFAULT,
    parameter int   CW       = VGA_CW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    output logic          H_Sync,
    output logic          V_Sync,
    output logic          Active,
    output logic [CW-1:0] Col,
    output logic [CW-1:0] Row,
    output logic          Line_Start,
    output logic          Frame_Start
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Packed word carried through the delay line:
    // {hsync, vsync, active, line_start, frame_start, col, row}
    localparam int PW = 5 + 2 * CW;

    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;

    logic          w_col_wrap;
    logic          w_row_wrap;
    logic          w_h_in_sync;
    logic          w_v_in_sync;
    logic          w_hsync_raw;
    logic          w_vsync_raw;
    logic          w_active_raw;
    logic          w_line_raw;
    logic          w_frame_raw;
    logic [PW-1:0] w_raw;
    logic [PW-1:0] w_idle;
    logic [PW-1:0] w_delayed;

    assign w_col_wrap = (r_col == H_LAST);
    assign w_row_wrap = (r_row == V_LAST);

    // Column runs every enabled cycle; the row only moves on the enabled
    // cycle where the column wraps, and wraps itself at the end of a frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (CE) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Raw decodes of the current counter position. Vertical sync depends on
    // the row alone, so it spans every column of the sync rows.
    assign w_h_in_sync  = (r_col >= H_SYNC_FIRST) && (r_col <= H_SYNC_LAST);
    assign w_v_in_sync  = (r_row >= V_SYNC_FIRST) && (r_row <= V_SYNC_LAST);
    assign w_hsync_raw  = w_h_in_sync ? H_POL : ~H_POL;
    assign w_vsync_raw  = w_v_in_sync ? V_POL : ~V_POL;
    assign w_active_raw = (r_col < H_ACT_END) && (r_row < V_ACT_END);
    assign w_line_raw   = (r_col == '0);
    assign w_frame_raw  = (r_col == '0) && (r_row == '0);

    assign w_raw  = {w_hsync_raw, w_vsync_raw, w_active_raw,
                     w_line_raw, w_frame_raw, r_col, r_row};

    // Idle word: syncs deasserted, no activity, no strobes, origin coords.
    assign w_idle = {~H_POL, ~V_POL, 1'b0, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}};

    // Coordinates share the delay line with the decodes so every output
    // describes the same pixel.
    vga_pipe_delay #(
        .WIDTH (PW),
        .DEPTH (PIPE)
    ) u_pipe (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_ce      (CE),
        .i_data    (w_raw),
        .i_rst_val (w_idle),
        .o_data    (w_delayed)
    );

    assign {H_Sync, V_Sync, Active, Line_Start, Frame_Start, Col, Row} = w_delayed;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Purpose : Self-checking bench for vga_timing_gen. dutA uses the default
//           640x480 timing; dutB uses a tiny 14x7 raster with PIPE=3 and an
//           active-high H sync so whole frames fit in a short run.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rstA, ceA, rstB, ceB;
    logic       hSyncA, vSyncA, activeA, lineStartA, frameStartA;
    logic       hSyncB, vSyncB, activeB, lineStartB, frameStartB;
    logic [9:0] colA, rowA, colB, rowB;
    logic [24:0] obsA, obsB;

    int checks   = 0;
    int failures = 0;
    bit invOn    = 1'b0;

    localparam logic [24:0] IDLE_A = {1'b1, 1'b1, 3'b000, 10'd0, 10'd0};
    localparam logic [24:0] IDLE_B = {1'b0, 1'b1, 3'b000, 10'd0, 10'd0};

    always #5 clk = ~clk;

    vga_timing_gen dutA (
        .CLK(clk), .RST(rstA), .CE(ceA),
        .H_Sync(hSyncA), .V_Sync(vSyncA), .Active(activeA),
        .Col(colA), .Row(rowA),
        .Line_Start(lineStartA), .Frame_Start(frameStartA)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .PIPE(3), .CW(10)
    ) dutB (
        .CLK(clk), .RST(rstB), .CE(ceB),
        .H_Sync(hSyncB), .V_Sync(vSyncB), .Active(activeB),
        .Col(colB), .Row(rowB),
        .Line_Start(lineStartB), .Frame_Start(frameStartB)
    );

    assign obsA = {hSyncA, vSyncA, activeA, lineStartA, frameStartA, colA, rowA};
    assign obsB = {hSyncB, vSyncB, activeB, lineStartB, frameStartB, colB, rowB};

    // Expected dutB output word after e enabled cycles since reset release:
    // 14 pixels/line, 7 lines/frame, H sync high at cols 10..11, V sync low
    // on row 5, visible region 8x4, first real pixel after 3 enabled cycles.
    function automatic logic [24:0] exp_small(input int e);
        int p, c, r;
        logic hs, vs, ac, ls, fs;
        if (e < 3) return IDLE_B;
        p  = (e - 3) % 98;
        c  = p % 14;
        r  = p / 14;
        hs = (c >= 10) && (c <= 11);
        vs = (r != 5);
        ac = (c < 8) && (r < 4);
        ls = (c == 0);
        fs = (p == 0);
        return {hs, vs, ac, ls, fs, 10'(c), 10'(r)};
    endfunction

    // Expected dutA output word: 800 pixels/line, active-low H sync on
    // cols 656..751, V sync low on rows 490..491, latency 2 enabled cycles.
    function automatic logic [24:0] exp_default(input int e);
        int p, c, r;
        logic hs, vs, ac, ls, fs;
        if (e < 2) return IDLE_A;
        p  = (e - 2) % 420000;
        c  = p % 800;
        r  = p / 800;
        hs = !((c >= 656) && (c <= 751));
        vs = !((r >= 490) && (r <= 491));
        ac = (c < 640) && (r < 480);
        ls = (c == 0);
        fs = (p == 0);
        return {hs, vs, ac, ls, fs, 10'(c), 10'(r)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Coordinate-range invariant for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (invOn) begin
            checks++;
            if ((activeB && (colB >= 10'd8 || rowB >= 10'd4)) || colB >= 10'd14 || rowB >= 10'd7 ||
                (activeA && (colA >= 10'd640 || rowA >= 10'd480)) || colA >= 10'd800 || rowA >= 10'd525) begin
                failures++;
                $display("[TB] FAIL invariant: A col=%0d row=%0d act=%b  B col=%0d row=%0d act=%b",
                         colA, rowA, activeA, colB, rowB, activeB);
            end
        end
    end

    task automatic test_reset();
        rstA = 1'b1; ceA = 1'b1; rstB = 1'b1; ceB = 1'b1;
        tick(); tick();
        checks++;
        if (obsA !== IDLE_A) begin
            failures++;
            $display("[TB] FAIL reset_A: got=%h required=%h", obsA, IDLE_A);
        end
        checks++;
        if (obsB !== IDLE_B) begin
            failures++;
            $display("[TB] FAIL reset_B: got=%h required=%h", obsB, IDLE_B);
        end
        invOn = 1'b1;
        // Let dutB run, then reset it while CE is low.
        rstB = 1'b0;
        repeat (20) tick();
        rstB = 1'b1; ceB = 1'b0;
        tick();
        checks++;
        if (obsB !== IDLE_B) begin
            failures++;
            $display("[TB] FAIL reset_ce0: got=%h required=%h", obsB, IDLE_B);
        end
    endtask

    task automatic test_small_frame();
        int firstFs = -1;
        int secondFs = -1;
        rstB = 1'b1; ceB = 1'b1;
        tick();
        rstB = 1'b0;
        for (int e = 1; e <= 3 + 98 * 2 + 5; e++) begin
            tick();
            checks++;
            if (obsB !== exp_small(e)) begin
                failures++;
                $display("[TB] FAIL small_frame e=%0d: got=%h required=%h", e, obsB, exp_small(e));
            end
            if (frameStartB === 1'b1) begin
                if (firstFs < 0) firstFs = e;
                else if (secondFs < 0) secondFs = e;
            end
        end
        checks++;
        if (firstFs !== 3) begin
            failures++;
            $display("[TB] FAIL small_latency: got=%0d required=3", firstFs);
        end
        checks++;
        if (secondFs - firstFs !== 98) begin
            failures++;
            $display("[TB] FAIL small_fs_period: got=%0d required=98", secondFs - firstFs);
        end
    endtask

    task automatic test_ce_toggle();
        int en = 0;
        int firstRise = -1;
        int secondRise = -1;
        logic prevFs = 1'b0;
        logic [24:0] prevObs;
        rstB = 1'b1; ceB = 1'b1;
        tick();
        rstB = 1'b0;
        prevObs = obsB;
        for (int k = 1; k <= 2 * (3 + 98 * 2) + 4; k++) begin
            ceB = (k % 2 == 1);
            tick();
            if (ceB) en++;
            checks++;
            if (obsB !== exp_small(en)) begin
                failures++;
                $display("[TB] FAIL ce_toggle k=%0d: got=%h required=%h", k, obsB, exp_small(en));
            end
            if (!ceB) begin
                checks++;
                if (obsB !== prevObs) begin
                    failures++;
                    $display("[TB] FAIL ce_freeze k=%0d: got=%h required=%h", k, obsB, prevObs);
                end
            end
            if (frameStartB === 1'b1 && prevFs === 1'b0) begin
                if (firstRise < 0) firstRise = k;
                else if (secondRise < 0) secondRise = k;
            end
            prevFs  = frameStartB;
            prevObs = obsB;
        end
        checks++;
        if (firstRise !== 5) begin
            failures++;
            $display("[TB] FAIL ce_first_fs: got=%0d required=5", firstRise);
        end
        checks++;
        if (secondRise - firstRise !== 196) begin
            failures++;
            $display("[TB] FAIL ce_fs_period: got=%0d required=196", secondRise - firstRise);
        end
        ceB = 1'b1;
    endtask

    task automatic test_mid_reset();
        rstB = 1'b1; ceB = 1'b1;
        tick();
        rstB = 1'b0;
        // After 47 enabled cycles the counters sit at row 3, col 5.
        repeat (47) tick();
        checks++;
        if (obsB !== exp_small(47)) begin
            failures++;
            $display("[TB] FAIL mid_pre: got=%h required=%h", obsB, exp_small(47));
        end
        rstB = 1'b1;
        tick();
        checks++;
        if (obsB !== IDLE_B) begin
            failures++;
            $display("[TB] FAIL mid_reset_idle: got=%h required=%h", obsB, IDLE_B);
        end
        rstB = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (obsB !== exp_small(e)) begin
                failures++;
                $display("[TB] FAIL mid_restart e=%0d: got=%h required=%h", e, obsB, exp_small(e));
            end
        end
    endtask

    task automatic test_default_line();
        int hLow = 0;
        int actCnt = 0;
        int fall1 = -1;
        int fall2 = -1;
        logic prevHs = 1'b1;
        rstA = 1'b1; ceA = 1'b1;
        tick();
        rstA = 1'b0;
        for (int e = 1; e <= 1700; e++) begin
            tick();
            checks++;
            if (obsA !== exp_default(e)) begin
                failures++;
                $display("[TB] FAIL default_line e=%0d: got=%h required=%h", e, obsA, exp_default(e));
            end
            if (e >= 2 && e < 802) begin
                if (hSyncA === 1'b0) hLow++;
                if (activeA === 1'b1) actCnt++;
            end
            if (prevHs === 1'b1 && hSyncA === 1'b0) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            prevHs = hSyncA;
        end
        checks++;
        if (hLow !== 96) begin
            failures++;
            $display("[TB] FAIL hsync_width: got=%0d required=96", hLow);
        end
        checks++;
        if (actCnt !== 640) begin
            failures++;
            $display("[TB] FAIL active_width: got=%0d required=640", actCnt);
        end
        checks++;
        if (fall2 - fall1 !== 800) begin
            failures++;
            $display("[TB] FAIL hsync_period: got=%0d required=800", fall2 - fall1);
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_ce_toggle();
        test_mid_reset();
        test_default_line();
        invOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
